// File: rtl/key_take_sequencer.sv
// key_take_sequencer: records the live key bitmap to external memory once per frame and replays it.
// Optional feature macro LOOP_PLAYBACK_EN: playback wraps to frame 0 at end of take instead of stopping.
module key_take_sequencer #(
  parameter int NUM_KEYS = 17,
  parameter int DATA_W   = 36,
  parameter int ADDR_W   = 19,
  parameter int DECIM    = 1,
  parameter int MEM_LAT  = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_ready,
  input  logic                i_record,
  input  logic                i_playback,
  input  logic [NUM_KEYS-1:0] i_key_num,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic                o_mem_we,
  output logic [NUM_KEYS-1:0] o_key_num_out,
  output logic [1:0]          o_state,
  output logic [ADDR_W:0]     o_take_len
);
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_we;
  logic [NUM_KEYS-1:0] r_key_out;
  logic [ADDR_W:0]     r_take_len;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [MEM_LAT-1:0]  r_rd_vld;
  logic                r_take_done;

  logic                w_frame_tick;
  logic [ADDR_W:0]     w_addr_inc;
  logic [ADDR_W:0]     w_take_last;
  logic                w_last_frame;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_unused_rdata;

  assign w_frame_tick   = i_ready && (r_frame_cnt == CNT_LAST);
  assign w_addr_inc     = {1'b0, r_addr} + LEN_ONE;
  assign w_take_last    = r_take_len - LEN_ONE;
  assign w_last_frame   = ({1'b0, r_addr} == w_take_last);
  assign w_unused_rdata = ^i_mem_rdata;

  always_comb begin
    w_wdata                = '0;
    w_wdata[NUM_KEYS-1:0]  = i_key_num;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_key_out   <= '0;
      r_take_len  <= '0;
      r_frame_cnt <= '0;
      r_rd_vld    <= '0;
      r_take_done <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (i_ready) r_frame_cnt <= w_frame_tick ? '0 : r_frame_cnt + CNT_ONE;

      case (r_state)
        S_IDLE: begin
          r_key_out <= i_key_num;
          if (i_record) begin
            r_state     <= S_RECORD;
            r_addr      <= '0;
            r_take_len  <= '0;
            r_frame_cnt <= '0;
          end else if (i_playback && (r_take_len != '0)) begin
            r_state     <= S_PLAY;
            r_addr      <= '0;
            r_frame_cnt <= '0;
            r_rd_vld    <= '0;
            r_take_done <= 1'b0;
          end
        end

        S_RECORD: begin
          r_key_out <= i_key_num;
          if (w_frame_tick) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_wdata;
            r_addr      <= w_addr_inc[ADDR_W-1:0];
            r_take_len  <= w_addr_inc;
          end
          // a write to the last address fills the memory and ends the take
          if (i_record || (w_frame_tick && (r_addr == ADDR_MAX))) r_state <= S_IDLE;
        end

        S_PLAY: begin
          if (i_playback) begin
            r_state     <= S_IDLE;
            r_rd_vld    <= '0;
            r_take_done <= 1'b0;
          end else begin
            for (int k = MEM_LAT - 1; k > 0; k--) r_rd_vld[k] <= r_rd_vld[k-1];
            r_rd_vld[0] <= w_frame_tick && !r_take_done;

            if (r_rd_vld[MEM_LAT-1]) begin
              r_key_out <= i_mem_rdata[NUM_KEYS-1:0];
              if (r_take_done) begin
                r_state     <= S_IDLE;
                r_take_done <= 1'b0;
              end
            end

            if (w_frame_tick && !r_take_done) begin
              r_mem_addr <= r_addr;
              if (w_last_frame) begin
`ifdef LOOP_PLAYBACK_EN
                r_addr <= '0;
`else
                r_addr      <= w_addr_inc[ADDR_W-1:0];
                r_take_done <= 1'b1;
`endif
              end else begin
                r_addr <= w_addr_inc[ADDR_W-1:0];
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_we      = r_mem_we;
  assign o_key_num_out = r_key_out;
  assign o_state       = r_state;
  assign o_take_len    = r_take_len;

endmodule

// File: tb/tb_key_take_sequencer.sv
// Bench for key_take_sequencer: unit A (depth 2**19, DECIM=1) and unit B (depth 8, DECIM=4), both MEM_LAT=2.
`timescale 1ns/1ps
module tb_key_take_sequencer;
  localparam int NK   = 17;
  localparam int DW   = 36;
  localparam int AW_A = 19;
  localparam int AW_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_ready, a_rec, a_play;
  logic [NK-1:0]   a_key, a_key_out;
  logic [DW-1:0]   a_rdata, a_wdata;
  logic [AW_A-1:0] a_addr;
  logic            a_we;
  logic [1:0]      a_state;
  logic [AW_A:0]   a_take_len;

  logic            b_ready, b_rec, b_play;
  logic [NK-1:0]   b_key, b_key_out;
  logic [DW-1:0]   b_rdata, b_wdata;
  logic [AW_B-1:0] b_addr;
  logic            b_we;
  logic [1:0]      b_state;
  logic [AW_B:0]   b_take_len;

  key_take_sequencer #(.NUM_KEYS(NK), .DATA_W(DW), .ADDR_W(AW_A), .DECIM(1), .MEM_LAT(2)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_ready(a_ready), .i_record(a_rec), .i_playback(a_play),
    .i_key_num(a_key), .i_mem_rdata(a_rdata), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
    .o_mem_we(a_we), .o_key_num_out(a_key_out), .o_state(a_state), .o_take_len(a_take_len)
  );

  key_take_sequencer #(.NUM_KEYS(NK), .DATA_W(DW), .ADDR_W(AW_B), .DECIM(4), .MEM_LAT(2)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_ready(b_ready), .i_record(b_rec), .i_playback(b_play),
    .i_key_num(b_key), .i_mem_rdata(b_rdata), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
    .o_mem_we(b_we), .o_key_num_out(b_key_out), .o_state(b_state), .o_take_len(b_take_len)
  );

  // External memories: data appears one register stage after the address, so it is
  // captured by the DUT two edges after the read is issued.
  logic [DW-1:0] mem_a [int unsigned];
  logic [DW-1:0] mem_b [8];

  always @(posedge clk) if (a_we === 1'b1) mem_a[32'(a_addr)] = a_wdata;
  always @(posedge clk) if (b_we === 1'b1) mem_b[b_addr] = b_wdata;
  always @(posedge clk) a_rdata <= mem_a.exists(32'(a_addr)) ? mem_a[32'(a_addr)] : '0;
  always @(posedge clk) b_rdata <= mem_b[b_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expected writes {addr, data} and expected playback bitmaps.
  logic [AW_A+DW-1:0] qa[$];
  logic [AW_A+DW-1:0] qb[$];
  logic [NK-1:0]      keyq[$];

  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      if (qa.size() == 0) check("a_extra_write", 64'(a_we), 64'd0);
      else begin
        logic [AW_A+DW-1:0] e;
        e = qa.pop_front();
        check("a_write_addr", 64'(a_addr), 64'(e[AW_A+DW-1:DW]));
        check("a_write_data", 64'(a_wdata), 64'(e[DW-1:0]));
        $display("write A addr=%0h data=%0h", a_addr, a_wdata);
      end
    end
    if (b_we === 1'b1) begin
      if (qb.size() == 0) check("b_extra_write", 64'(b_we), 64'd0);
      else begin
        logic [AW_A+DW-1:0] e;
        e = qb.pop_front();
        check("b_write_addr", 64'(b_addr), 64'(e[AW_A+DW-1:DW]));
        check("b_write_data", 64'(b_wdata), 64'(e[DW-1:0]));
        $display("write B addr=%0h data=%0h", b_addr, b_wdata);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [NK-1:0] klist [3];
    klist = '{17'h00001, 17'h00002, 17'h00004};
    a_ready = 0; a_rec = 0; a_play = 0; a_key = '0;
    b_ready = 0; b_rec = 0; b_play = 0; b_key = '0;

    cyc(2);
    check("rst_a_state", 64'(a_state), 64'd0);
    check("rst_a_take_len", 64'(a_take_len), 64'd0);
    check("rst_a_we", 64'(a_we), 64'd0);
    check("rst_a_key_out", 64'(a_key_out), 64'd0);
    check("rst_a_addr", 64'(a_addr), 64'd0);
    check("rst_b_wdata", 64'(b_wdata), 64'd0);
    rst = 0;
    cyc(1);

    // Playback with no stored take is ignored
    a_play = 1; cyc(1); a_play = 0;
    check("a_play_empty_state", 64'(a_state), 64'd0);
    $display("A playback with empty take state=%0d", a_state);

    // Record three frames
    a_rec = 1; cyc(1); a_rec = 0;
    check("a_rec_state", 64'(a_state), 64'd1);
    check("a_rec_take_len0", 64'(a_take_len), 64'd0);
    for (int i = 0; i < 3; i++) begin
      a_key = klist[i];
      qa.push_back({AW_A'(i), DW'(klist[i])});
      a_ready = 1; cyc(1); a_ready = 0;
      check("a_rec_take_len", 64'(a_take_len), 64'(i + 1));
      cyc(2);
    end
    a_rec = 1; cyc(1); a_rec = 0;
    check("a_rec_stop_state", 64'(a_state), 64'd0);
    check("a_rec_stop_take_len", 64'(a_take_len), 64'd3);
    check("a_writes_drained", 64'(qa.size()), 64'd0);
    a_key = 17'h00155; cyc(1);
    check("a_idle_live_key", 64'(a_key_out), 64'h155);
    $display("A record done take_len=%0d", a_take_len);

    // Playback
    a_key = 17'h000AA;
    a_play = 1; cyc(1); a_play = 0;
    check("a_play_state", 64'(a_state), 64'd2);
    for (int i = 0; i < 3; i++) begin
      keyq.push_back(klist[i]);
      a_ready = 1; cyc(1); a_ready = 0;
      check("a_play_addr", 64'(a_addr), 64'(i));
      check("a_play_we", 64'(a_we), 64'd0);
      cyc(2);
      check("a_play_key", 64'(a_key_out), 64'(keyq.pop_front()));
      $display("A play frame %0d key_out=%0h state=%0d", i, a_key_out, a_state);
    end
`ifdef LOOP_PLAYBACK_EN
    check("a_loop_state", 64'(a_state), 64'd2);
    keyq.push_back(klist[0]);
    a_ready = 1; cyc(1); a_ready = 0;
    check("a_loop_addr", 64'(a_addr), 64'd0);
    cyc(2);
    check("a_loop_key", 64'(a_key_out), 64'(keyq.pop_front()));
    a_play = 1; cyc(1); a_play = 0;
    check("a_loop_exit_state", 64'(a_state), 64'd0);
`else
    check("a_end_state", 64'(a_state), 64'd0);
    cyc(1);
    check("a_end_live_key", 64'(a_key_out), 64'hAA);
`endif

    // Record and playback together: record wins, old take discarded
    a_rec = 1; a_play = 1; cyc(1); a_rec = 0; a_play = 0;
    check("a_both_state", 64'(a_state), 64'd1);
    check("a_both_take_len", 64'(a_take_len), 64'd0);
    a_rec = 1; cyc(1); a_rec = 0;
    check("a_both_stop_state", 64'(a_state), 64'd0);
    $display("A record+playback state went to RECORD and back");

    // Unit B: every 4th ready writes; full memory stops after 8 frames
    b_rec = 1; cyc(1); b_rec = 0;
    check("b_rec_state", 64'(b_state), 64'd1);
    for (int r = 0; r < 36; r++) begin
      b_key = NK'((r / 4) * 3 + 5);
      if ((r % 4 == 3) && (r < 32)) qb.push_back({AW_A'(r / 4), DW'(b_key)});
      b_ready = 1; cyc(1); b_ready = 0;
      check("b_we_decim", 64'(b_we), 64'((r % 4 == 3) && (r < 32)));
      cyc(1);
    end
    check("b_full_state", 64'(b_state), 64'd0);
    check("b_full_take_len", 64'(b_take_len), 64'd8);
    check("b_writes_drained", 64'(qb.size()), 64'd0);
    $display("B record full take_len=%0d", b_take_len);

    // Unit B playback, then reset mid-cycle
    b_play = 1; cyc(1); b_play = 0;
    check("b_play_state", 64'(b_state), 64'd2);
    for (int f = 0; f < 2; f++) begin
      keyq.push_back(NK'(f * 3 + 5));
      for (int j = 0; j < 4; j++) begin
        b_ready = 1; cyc(1); b_ready = 0;
        if (j < 3) begin
          check("b_play_no_read", 64'(b_addr), 64'((f == 0) ? 7 : f - 1));
          cyc(1);
        end else begin
          check("b_play_addr", 64'(b_addr), 64'(f));
          cyc(2);
        end
      end
      check("b_play_key", 64'(b_key_out), 64'(keyq.pop_front()));
      $display("B play frame %0d key_out=%0h", f, b_key_out);
    end
    #2;
    rst = 1;
    #1;
    check("b_async_state", 64'(b_state), 64'd0);
    check("b_async_take_len", 64'(b_take_len), 64'd0);
    check("b_async_key_out", 64'(b_key_out), 64'd0);
    check("b_async_we", 64'(b_we), 64'd0);
    check("b_async_addr", 64'(b_addr), 64'd0);
    $display("B async reset state=%0d take_len=%0d", b_state, b_take_len);
    cyc(1);
    rst = 0;
    cyc(1);
    b_play = 1; cyc(1); b_play = 0;
    check("b_play_after_reset", 64'(b_state), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
